matrix_compute_unit: RTL and testbench
======================================

# matrix_compute_unit

Sequential 4x4 matrix arithmetic stage of the Simple Matrix Engine. It sits directly downstream of `memory`. Two 256-bit words from the memory `dataBus` are presented as operands A and B. The unit computes a 4x4 product, sum, difference or transpose. The 256-bit result is produced on a bus suitable for driving the memory `inputBus` for write-back. A start/busy/done handshake lets the sequencer issue a `readFromMem`/`writeToMem` around each operation.

## Interface
- No parameters. Data width is fixed at 16 bits per element, 4x4 elements, 256 bits per matrix.
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request an operation; sampled only in IDLE
- opcode  input  2  00 = A*B, 01 = A+B, 10 = A-B, 11 = transpose(A); B is ignored
- aIn  input  256  operand A, in the same packing as the memory data bus
- bIn  input  256  operand B, in the same packing as the memory data bus
- result  output  256  result matrix, held stable outside COMPUTE
- busy  output  1  high while an accepted operation is in progress
- done  output  1  one-cycle pulse when `result` is complete

## Operation
- **Element packing:** element (r,c), r,c in 0..3, occupies bits [255-16*(4r+c) -: 16]. Row 0 col 0 is in the MSBs; hex reads row-major left to right.
- **Arithmetic:** all arithmetic is unsigned modulo 2^16.
  - Products: each 16x16 product is truncated to the low 16 bits before accumulation.
  - Dot products: the 4-term dot product is also truncated to 16 bits.
  - Add and subtract wrap, with no saturation and no flags.
- **States:** IDLE, COMPUTE, DONE.
- **IDLE:**
  - With start=1 at a rising edge: latch aIn, bIn and opcode into internal registers, clear `result` to 0, clear the element index to 0, and go to COMPUTE.
  - Later changes on aIn, bIn or opcode have no effect until the next accepted start.
- **COMPUTE with opcode 00:**
  - One result element per cycle, in row-major order k = 0..15.
  - Element k = sum over j of A(k/4, j) * B(j, k%4).
  - The index increments each cycle. After element 15 is written, go to DONE.
- **COMPUTE with opcode 01, 10 or 11:** the whole result is written in one cycle, then go to DONE.
- **DONE:** done=1 for exactly one cycle, then return to IDLE unconditionally.
- **Ignored start:** start is ignored in COMPUTE and DONE. It is not queued.
- **Result retention:** `result` holds its value from DONE until the next accepted start.
- **Reset (reset=0) at any time, including mid-operation:**
  - Immediately: state IDLE, result = 0, busy = 0, done = 0, element index = 0.
  - Latched operands are cleared to 0.
  - The aborted operation is lost.

## Timing
- Edge 0 is the rising edge at which start is accepted.
- **busy:** goes 1 after edge 0 and stays 1 through the last COMPUTE cycle. It is 0 in IDLE and DONE.
- **opcode 00 (multiply):**
  - Element k becomes visible after edge k+1.
  - done=1 after edge 16 and returns to 0 after edge 17.
  - Latency from start to done is 16 cycles.
- **opcode 01/10/11:**
  - Full result visible after edge 1.
  - done=1 after edge 1 and returns to 0 after edge 2.
- **Back-to-back operations:** the earliest next accepted start is at the edge where done falls (DONE to IDLE), plus one. In other words, start must be high in IDLE.
- **Partial results:** during multiply, `result` shows partial results. Elements not yet computed read 0. Consumers use only values qualified by done.
- **Reset outputs:** all outputs read 0 while reset=0, and remain 0 until the first accepted start.

## Test plan
- **Identity multiply:**
  - Stimulus: A = identity (0001 on the diagonal, else 0000); B = 256'h0017_002d_0043_0016_0007_0006_0004_0001_0012_0038_000d_000c_0003_0005_0007_0009; opcode 00; one-cycle start.
  - Required: result == B exactly 16 cycles after the accepting edge; done high exactly one cycle; busy high for 16 cycles.
- **Wrapping add/subtract:**
  - Stimulus: A with all elements FFFF, B with all elements 0002.
  - Required: opcode 01 gives every element 0001. With A all 0000 and B all 0001, opcode 10 gives every element FFFF. Each completes with done after edge 1.
- **Transpose:**
  - Stimulus: A = 256'h0000_0001_0002_..._000f (element k = k); opcode 11.
  - Required: element (r,c) == 4c+r, e.g. the second 16-bit word is 0004; bIn contents have no effect.
- **Truncated multiply:**
  - Stimulus: A and B with all elements 0100; opcode 00.
  - Required: each product 0x10000 truncates to 0000, so every result element is 0000. Separately, with all elements 00ff, every element is 4*0xfe01 mod 2^16 = 0xf804.
- **Start and operand changes while busy:**
  - Stimulus: during a multiply, pulse start at cycle 5 with opcode 01, and change aIn/bIn at cycle 3.
  - Required: the pulse is ignored; the multiply finishes with the original operands; only one done pulse occurs.
- **Reset mid-operation:**
  - Stimulus: assert reset=0 asynchronously (between clock edges) at cycle 8 of a multiply.
  - Required: result, busy and done read 0 immediately. After release, a new start completes normally with correct values.

Source files
------------

// File: rtl/matrix_compute_unit_if.sv
// Operand/result bus between the matrix sequencer (master) and matrix_compute_unit (slave).
// Operand and result words use the same packing as the memory data bus.
interface matrix_compute_unit_if;
  localparam int unsigned MAT_W = 256;
  localparam int unsigned OP_W  = 2;

  logic               start;
  logic [OP_W-1:0]    opcode;
  logic [MAT_W-1:0]   aIn;
  logic [MAT_W-1:0]   bIn;
  logic [MAT_W-1:0]   result;
  logic               busy;
  logic               done;

  modport master (output start, opcode, aIn, bIn, input result, busy, done);
  modport slave  (input start, opcode, aIn, bIn, output result, busy, done);
endinterface

// File: rtl/matrix_compute_unit.sv
// Sequential 4x4 x 16-bit matrix multiply/add/subtract/transpose stage.
// Multiply emits one element per cycle; the other ops finish in a single cycle.
module matrix_compute_unit (
  input  logic                  clk,
  input  logic                  reset,
  matrix_compute_unit_if.slave  mat
);
  localparam int unsigned EL_W  = 16;
  localparam int unsigned DIM   = 4;
  localparam int unsigned N_EL  = DIM * DIM;
  localparam int unsigned MAT_W = EL_W * N_EL;
  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_TRN = 2'b11;

  logic [1:0]       state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [MAT_W-1:0] a_q, a_next, b_q, b_next;
  logic [1:0]       op_q, op_next;
  logic [MAT_W-1:0] result_q, result_next;
  logic             busy_q, done_q;
  logic [EL_W-1:0]  dot;

  // Element k (row-major) lives at bits [16*(15-k) +: 16], so (0,0) sits in the MSBs.
  function automatic logic [EL_W-1:0] elem(input logic [MAT_W-1:0] m, input int unsigned k);
    return m[EL_W*(N_EL-1-k) +: EL_W];
  endfunction

  // Dot product of row idx/4 of A with column idx%4 of B, everything mod 2^16.
  always_comb begin
    dot = '0;
    for (int unsigned j = 0; j < DIM; j++) begin
      dot = EL_W'(dot + EL_W'(elem(a_q, DIM * 32'(idx[3:2]) + j) *
                              elem(b_q, DIM * j + 32'(idx[1:0]))));
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    a_next      = a_q;
    b_next      = b_q;
    op_next     = op_q;
    result_next = result_q;
    case (state)
      ST_IDLE: begin
        if (mat.start) begin
          a_next      = mat.aIn;
          b_next      = mat.bIn;
          op_next     = mat.opcode;
          result_next = '0;
          idx_next    = '0;
          state_next  = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (op_q == OP_MUL) begin
          result_next[EL_W*(N_EL-1-32'(idx)) +: EL_W] = dot;
          idx_next = IDX_W'(idx + IDX_W'(1));
          if (idx == IDX_W'(N_EL - 1)) state_next = ST_DONE;
        end else begin
          for (int unsigned k = 0; k < N_EL; k++) begin
            case (op_q)
              OP_ADD:  result_next[EL_W*(N_EL-1-k) +: EL_W] = EL_W'(elem(a_q, k) + elem(b_q, k));
              OP_SUB:  result_next[EL_W*(N_EL-1-k) +: EL_W] = EL_W'(elem(a_q, k) - elem(b_q, k));
              OP_TRN:  result_next[EL_W*(N_EL-1-k) +: EL_W] = elem(a_q, DIM * (k % DIM) + k / DIM);
              default: result_next[EL_W*(N_EL-1-k) +: EL_W] = '0;
            endcase
          end
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      a_q      <= a_next;
      b_q      <= b_next;
      op_q     <= op_next;
      result_q <= result_next;
      busy_q   <= (state_next == ST_COMPUTE);
      done_q   <= (state_next == ST_DONE);
    end
  end

  assign mat.result = result_q;
  assign mat.busy   = busy_q;
  assign mat.done   = done_q;
endmodule

// File: tb/tb_matrix_compute_unit.sv
// Randomized and directed bench for matrix_compute_unit against a row/column reference model.
module tb_matrix_compute_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  matrix_compute_unit_if bus ();

  matrix_compute_unit dut (
    .clk   (clk),
    .reset (rst_n),
    .mat   (bus.slave)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] el(input logic [255:0] m, input int r, input int c);
    return m[255-16*(4*r+c) -: 16];
  endfunction

  function automatic logic [255:0] ref_op(input logic [1:0] op, input logic [255:0] a,
                                          input logic [255:0] b);
    logic [255:0] res;
    longint v;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (op)
          2'b00: begin
            v = 0;
            for (int j = 0; j < 4; j++)
              v += (longint'(el(a, r, j)) * longint'(el(b, j, c))) % 65536;
            v = v % 65536;
          end
          2'b01:   v = (longint'(el(a, r, c)) + longint'(el(b, r, c))) % 65536;
          2'b10:   v = (65536 + longint'(el(a, r, c)) - longint'(el(b, r, c))) % 65536;
          default: v = longint'(el(a, c, r));
        endcase
        res[255-16*(4*r+c) -: 16] = 16'(v);
      end
    end
    return res;
  endfunction

  // What the result register should show after n multiply elements have been written.
  function automatic logic [255:0] partial(input logic [255:0] full, input int n);
    logic [255:0] res;
    res = full;
    for (int k = n; k < 16; k++) res[255-16*k -: 16] = 16'h0;
    return res;
  endfunction

  function automatic logic [255:0] rnd_mat();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [255:0] a, input logic [255:0] b,
                        input bit disturb, input string tag);
    logic [255:0] exp;
    int cnt;
    int lat;
    bit seen;
    exp = ref_op(op, a, b);
    lat = (op == 2'b00) ? 16 : 1;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.aIn = a; bus.bIn = b;
    @(posedge clk); #1;
    check({tag, "_busy_edge0"}, 256'(bus.busy), 256'(1'b1));
    check({tag, "_clear_edge0"}, bus.result, '0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.opcode = 2'($urandom);
    bus.aIn = rnd_mat();
    bus.bIn = rnd_mat();
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.done) seen = 1'b1;
      else check({tag, "_busy_mid"}, 256'(bus.busy), 256'(1'b1));
      if (op == 2'b00 && cnt <= 16) check({tag, "_partial"}, bus.result, partial(exp, cnt));
      if (disturb) begin
        @(negedge clk);
        if (cnt == 3) begin bus.aIn = rnd_mat(); bus.bIn = rnd_mat(); end
        if (cnt == 5) begin bus.start = 1'b1; bus.opcode = 2'b01; end
        if (cnt == 6) bus.start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 256'(seen), 256'(1'b1));
    check({tag, "_latency"}, 256'(cnt), 256'(lat));
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_busy_done"}, 256'(bus.busy), 256'(1'b0));
    repeat (2) begin
      @(posedge clk); #1;
      check({tag, "_done_fall"}, 256'(bus.done), 256'(1'b0));
      check({tag, "_busy_idle"}, 256'(bus.busy), 256'(1'b0));
      check({tag, "_hold"}, bus.result, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ident, bvec, seq;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.opcode = 2'b00; bus.aIn = '0; bus.bIn = '0;
    #12;
    check("rst_result", bus.result, '0);
    check("rst_busy", 256'(bus.busy), 256'(1'b0));
    check("rst_done", 256'(bus.done), 256'(1'b0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_result", bus.result, '0);
    check("post_rst_busy", 256'(bus.busy), 256'(1'b0));

    ident = '0;
    for (int i = 0; i < 4; i++) ident[255-16*(5*i) -: 16] = 16'h0001;
    bvec = 256'h0017_002d_0043_0016_0007_0006_0004_0001_0012_0038_000d_000c_0003_0005_0007_0009;
    run_op(2'b00, ident, bvec, 1'b0, "ident");
    check("ident_eq_b", bus.result, bvec);

    run_op(2'b01, {16{16'hffff}}, {16{16'h0002}}, 1'b0, "add_wrap");
    check("add_wrap_val", bus.result, {16{16'h0001}});
    run_op(2'b10, {16{16'h0000}}, {16{16'h0001}}, 1'b0, "sub_wrap");
    check("sub_wrap_val", bus.result, {16{16'hffff}});

    for (int k = 0; k < 16; k++) seq[255-16*k -: 16] = 16'(k);
    run_op(2'b11, seq, rnd_mat(), 1'b0, "transpose");
    check("transpose_w1", 256'(bus.result[239:224]), 256'(16'h0004));

    run_op(2'b00, {16{16'h0100}}, {16{16'h0100}}, 1'b0, "mul_trunc0");
    check("mul_trunc0_val", bus.result, '0);
    run_op(2'b00, {16{16'h00ff}}, {16{16'h00ff}}, 1'b0, "mul_ff");
    check("mul_ff_val", bus.result, {16{16'hf804}});

    run_op(2'b00, rnd_mat(), rnd_mat(), 1'b1, "disturb");

    // Abort a multiply between clock edges, then confirm a clean restart.
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 2'b00; bus.aIn = rnd_mat(); bus.bIn = rnd_mat();
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", bus.result, '0);
    check("abort_busy", 256'(bus.busy), 256'(1'b0));
    check("abort_done", 256'(bus.done), 256'(1'b0));
    @(posedge clk); #1;
    check("abort_hold_busy", 256'(bus.busy), 256'(1'b0));
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b00, rnd_mat(), rnd_mat(), 1'b0, "after_abort");

    for (int i = 0; i < 24; i++) run_op(2'($urandom), rnd_mat(), rnd_mat(), 1'b0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
